// File: rtl/router_rx_pkg.sv
// Shared types and helpers for the router input-port receiver.
package router_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    PAD,
    DATA,
    DROP
  } rx_state_e;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_SHORT   = 3'd1,
    ERR_PAD     = 3'd2,
    ERR_PARTIAL = 3'd3,
    ERR_PROTO   = 3'd4,
    ERR_LONG    = 3'd5
  } rx_err_e;

  // Counter width able to index 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/router_sipo.sv
// Serial-in/parallel-out shift register, LSB first, with bit counter.
// word presents the completed word combinationally in the cycle whose
// shift fills it, so the caller can register it alongside word_done.
module router_sipo
  import router_rx_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         shift_en,
  input  logic         clear,
  input  logic         din,
  output logic [W-1:0] word,
  output logic         word_done
);

  localparam int CW = cnt_width(W);

  logic [CW-1:0] bit_cnt;

  assign word_done = shift_en && (bit_cnt == CW'(W - 1));

  // Bit position within the current word; wraps after the final bit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt <= '0;
    end else if (clear || word_done) begin
      bit_cnt <= '0;
    end else if (shift_en) begin
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  if (W == 1) begin : g_single
    assign word = din;
  end else begin : g_multi
    // Only W-1 bits are stored: the newest bit comes straight from din.
    logic [W-2:0] sr;

    assign word = {din, sr};

    // Shift right so the first received bit ends up at bit 0.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        sr <= '0;
      end else if (clear) begin
        sr <= '0;
      end else if (shift_en) begin
        sr <= word[W-1:1];
      end
    end
  end

endmodule

// File: rtl/router_port_rx.sv
// Serial packet receiver for one router input port: address, pad,
// valid_n-qualified payload bytes, protocol error reporting.
module router_port_rx
  import router_rx_pkg::*;
#(
  parameter  int N_PORTS    = 16,
  parameter  int PAD_CYCLES = 5,
  parameter  int BYTE_W     = 8,
  parameter  int MAX_BYTES  = 64,
  localparam int ADDR_W     = $clog2(N_PORTS)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              din,
  input  logic              frame_n,
  input  logic              valid_n,
  output logic              hdr_valid,
  output logic [ADDR_W-1:0] hdr_dest,
  output logic              byte_valid,
  output logic [BYTE_W-1:0] byte_data,
  output logic              byte_last,
  output logic              err_valid,
  output logic [2:0]        err_code
);

  localparam int PC_W = cnt_width(PAD_CYCLES);
  localparam int BC_W = $clog2(MAX_BYTES + 1);

  rx_state_e         state, state_d;
  logic [PC_W-1:0]   pad_cnt, pad_cnt_d;
  logic [BC_W-1:0]   byte_cnt, byte_cnt_d;
  logic              at_max;

  logic              addr_shift, addr_clear, addr_done;
  logic [ADDR_W-1:0] addr_word;
  logic              data_shift, data_clear, data_done;
  logic [BYTE_W-1:0] data_word;

  logic              hdr_valid_d, byte_valid_d, byte_last_d, err_valid_d;
  logic [ADDR_W-1:0] hdr_dest_d;
  logic [BYTE_W-1:0] byte_data_d;
  rx_err_e           err_q, err_d;

  assign at_max     = (byte_cnt == BC_W'(MAX_BYTES));
  assign addr_shift = !frame_n && (state == IDLE || state == ADDR);
  assign data_shift = (state == DATA) && !valid_n && !at_max;
  // Clearing whenever the field is not continuing also recovers the bit
  // counters after an aborted field, so back-to-back frames start clean.
  assign addr_clear = (state_d != ADDR);
  assign data_clear = (state_d != DATA);

  router_sipo #(.W(ADDR_W)) u_addr_sipo (
    .clock     (clock),
    .reset_n   (reset_n),
    .shift_en  (addr_shift),
    .clear     (addr_clear),
    .din       (din),
    .word      (addr_word),
    .word_done (addr_done)
  );

  router_sipo #(.W(BYTE_W)) u_data_sipo (
    .clock     (clock),
    .reset_n   (reset_n),
    .shift_en  (data_shift),
    .clear     (data_clear),
    .din       (din),
    .word      (data_word),
    .word_done (data_done)
  );

  // Next-state and next-output decode for the receive FSM.
  always_comb begin
    state_d      = state;
    pad_cnt_d    = '0;
    byte_cnt_d   = byte_cnt;
    hdr_valid_d  = 1'b0;
    hdr_dest_d   = hdr_dest;
    byte_valid_d = 1'b0;
    byte_data_d  = byte_data;
    byte_last_d  = 1'b0;
    err_valid_d  = 1'b0;
    err_d        = err_q;

    unique case (state)
      IDLE: begin
        if (!frame_n) begin
          // addr_done here only when the address is a single bit.
          if (addr_done) begin
            hdr_valid_d = 1'b1;
            hdr_dest_d  = addr_word;
            state_d     = PAD;
          end else begin
            state_d = ADDR;
          end
        end
      end
      ADDR: begin
        if (frame_n) begin
          err_valid_d = 1'b1;
          err_d       = ERR_SHORT;
          state_d     = IDLE;
        end else if (addr_done) begin
          hdr_valid_d = 1'b1;
          hdr_dest_d  = addr_word;
          state_d     = PAD;
        end
      end
      PAD: begin
        if (frame_n) begin
          err_valid_d = 1'b1;
          err_d       = ERR_SHORT;
          state_d     = IDLE;
        end else if (!valid_n) begin
          err_valid_d = 1'b1;
          err_d       = ERR_PAD;
          state_d     = DROP;
        end else if (pad_cnt == PC_W'(PAD_CYCLES - 1)) begin
          state_d = DATA;
        end else begin
          pad_cnt_d = pad_cnt + 1'b1;
        end
      end
      DATA: begin
        if (!valid_n) begin
          if (at_max) begin
            // Frame already closing: nothing left to drop.
            err_valid_d = 1'b1;
            err_d       = ERR_LONG;
            state_d     = frame_n ? IDLE : DROP;
          end else if (data_done) begin
            byte_valid_d = 1'b1;
            byte_data_d  = data_word;
            byte_cnt_d   = byte_cnt + 1'b1;
            if (frame_n) begin
              byte_last_d = 1'b1;
              state_d     = IDLE;
            end
          end else if (frame_n) begin
            err_valid_d = 1'b1;
            err_d       = ERR_PARTIAL;
            state_d     = IDLE;
          end
        end else if (frame_n) begin
          err_valid_d = 1'b1;
          err_d       = ERR_PROTO;
          state_d     = IDLE;
        end
      end
      DROP: begin
        if (frame_n) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d != DATA) begin
      byte_cnt_d = '0;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      pad_cnt    <= '0;
      byte_cnt   <= '0;
      hdr_valid  <= 1'b0;
      hdr_dest   <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      byte_last  <= 1'b0;
      err_valid  <= 1'b0;
      err_q      <= ERR_NONE;
    end else begin
      state      <= state_d;
      pad_cnt    <= pad_cnt_d;
      byte_cnt   <= byte_cnt_d;
      hdr_valid  <= hdr_valid_d;
      hdr_dest   <= hdr_dest_d;
      byte_valid <= byte_valid_d;
      byte_data  <= byte_data_d;
      byte_last  <= byte_last_d;
      err_valid  <= err_valid_d;
      err_q      <= err_d;
    end
  end

  assign err_code = err_q;

endmodule

// File: tb/tb_router_port_rx.sv
// Self-checking bench for router_port_rx: a packet builder produces the
// serial stream together with the expected output events per cycle.
module tb_router_port_rx;

  localparam int AW   = 4;
  localparam int PADC = 5;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  logic din     = 1'b0;
  logic frame_n = 1'b1;
  logic valid_n = 1'b1;

  logic       hv [2];
  logic [3:0] hd [2];
  logic       bv [2];
  logic [7:0] bd [2];
  logic       bl [2];
  logic       ev [2];
  logic [2:0] ec [2];

  router_port_rx #(.N_PORTS(16), .PAD_CYCLES(PADC), .BYTE_W(8), .MAX_BYTES(64)) dut (
    .clock(clock), .reset_n(reset_n), .din(din), .frame_n(frame_n), .valid_n(valid_n),
    .hdr_valid(hv[0]), .hdr_dest(hd[0]), .byte_valid(bv[0]), .byte_data(bd[0]),
    .byte_last(bl[0]), .err_valid(ev[0]), .err_code(ec[0])
  );

  router_port_rx #(.N_PORTS(16), .PAD_CYCLES(PADC), .BYTE_W(8), .MAX_BYTES(4)) dut4 (
    .clock(clock), .reset_n(reset_n), .din(din), .frame_n(frame_n), .valid_n(valid_n),
    .hdr_valid(hv[1]), .hdr_dest(hd[1]), .byte_valid(bv[1]), .byte_data(bd[1]),
    .byte_last(bl[1]), .err_valid(ev[1]), .err_code(ec[1])
  );

  initial forever #5 clock = ~clock;

  typedef struct {
    bit       hv;
    bit [3:0] hd;
    bit       bv;
    bit [7:0] bd;
    bit       bl;
    bit       ev;
    bit [2:0] ec;
  } exp_t;

  int        n_tests = 0;
  int        n_fail  = 0;
  string     cur     = "";
  int        maxb [2] = '{64, 4};
  bit [2:0]  held [2] = '{3'd0, 3'd0};

  bit   s_f[$], s_v[$], s_d[$];
  exp_t ex0[$], ex1[$];
  bit   pbits[$];
  int   pgap[$];

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  function automatic void push_cyc(input bit f, input bit v, input bit d);
    exp_t z;
    z = '{default: '0};
    s_f.push_back(f); s_v.push_back(v); s_d.push_back(d);
    ex0.push_back(z); ex1.push_back(z);
  endfunction

  // kind 0 = header, 1 = byte, 2 = error; attached to the latest cycle
  function automatic void mark(input int d, input int kind, input int val, input bit last);
    int   i;
    exp_t t;
    i = s_f.size() - 1;
    t = (d == 0) ? ex0[i] : ex1[i];
    case (kind)
      0:       begin t.hv = 1'b1; t.hd = val[3:0]; end
      1:       begin t.bv = 1'b1; t.bd = val[7:0]; t.bl = last; end
      default: begin t.ev = 1'b1; t.ec = val[2:0]; end
    endcase
    if (d == 0) ex0[i] = t; else ex1[i] = t;
  endfunction

  function automatic void idle(input int n);
    for (int i = 0; i < n; i++) push_cyc(1'b1, 1'b1, rb());
  endfunction

  function automatic void clear_payload();
    pbits.delete(); pgap.delete();
  endfunction

  function automatic void add_byte(input bit [7:0] b, input int gap_pct);
    for (int j = 0; j < 8; j++) begin
      pbits.push_back(b[j]);
      pgap.push_back(($urandom_range(0, 99) < gap_pct) ? $urandom_range(1, 3) : 0);
    end
  endfunction

  function automatic void add_rand(input int n, input int gap_pct);
    for (int k = 0; k < n; k++) add_byte(8'($urandom_range(0, 255)), gap_pct);
  endfunction

  // Append one frame. short_at>0: frame ends after that many address bits.
  // pad_err_at>=0: valid_n low in that pad cycle. proto_end: frame closes
  // with valid_n high after the payload instead of on the last bit.
  function automatic void gen_packet(input int addr, input int short_at,
                                     input int pad_err_at, input bit proto_end);
    bit [3:0] a;
    bit       dead [2];
    bit       fr;
    bit [7:0] bval;
    int       nb;
    a  = addr[3:0];
    nb = pbits.size();
    dead = '{1'b0, 1'b0};
    if (short_at > 0) begin
      for (int i = 0; i < short_at; i++) push_cyc(1'b0, 1'b1, a[i]);
      push_cyc(1'b1, 1'b1, rb());
      for (int d = 0; d < 2; d++) mark(d, 2, 1, 1'b0);
      return;
    end
    for (int i = 0; i < AW; i++) push_cyc(1'b0, 1'b1, a[i]);
    for (int d = 0; d < 2; d++) mark(d, 0, addr, 1'b0);
    for (int p = 0; p < PADC; p++) begin
      push_cyc(1'b0, (p == pad_err_at) ? 1'b0 : 1'b1, rb());
      if (p == pad_err_at) begin
        for (int d = 0; d < 2; d++) mark(d, 2, 2, 1'b0);
        for (int t = 0; t < int'($urandom_range(0, 6)); t++) push_cyc(1'b0, rb(), rb());
        push_cyc(1'b1, rb(), rb());
        return;
      end
    end
    for (int i = 0; i < nb; i++) begin
      for (int g = 0; g < pgap[i]; g++) push_cyc(1'b0, 1'b1, rb());
      fr = (i == nb - 1) && !proto_end;
      push_cyc(fr, 1'b0, pbits[i]);
      for (int d = 0; d < 2; d++) begin
        if (!dead[d]) begin
          if (i / 8 >= maxb[d]) begin
            mark(d, 2, 5, 1'b0);
            dead[d] = 1'b1;
          end else if (i % 8 == 7) begin
            for (int j = 0; j < 8; j++) bval[j] = pbits[i - 7 + j];
            mark(d, 1, int'(bval), fr);
          end else if (fr) begin
            mark(d, 2, 3, 1'b0);
            dead[d] = 1'b1;
          end
        end
      end
    end
    if (proto_end) begin
      push_cyc(1'b1, 1'b1, rb());
      for (int d = 0; d < 2; d++) if (!dead[d]) mark(d, 2, 4, 1'b0);
    end
  endfunction

  // Drive the built stream (first stop_at cycles if stop_at>=0) and check.
  task automatic run_stream(input int stop_at);
    int       n;
    exp_t     e;
    bit [4:0] oh, eh;
    bit [9:0] ob, eb;
    bit [3:0] oe, ee;
    n = (stop_at >= 0 && stop_at < s_f.size()) ? stop_at : s_f.size();
    for (int c = 0; c < n; c++) begin
      @(negedge clock);
      frame_n = s_f[c]; valid_n = s_v[c]; din = s_d[c];
      @(posedge clock); #1;
      for (int d = 0; d < 2; d++) begin
        e  = (d == 0) ? ex0[c] : ex1[c];
        if (e.ev) held[d] = e.ec;
        oh = {hv[d], hv[d] ? hd[d] : 4'h0};
        eh = {e.hv, e.hd};
        ob = {bv[d], bv[d] ? {bd[d], bl[d]} : 9'h0};
        eb = {e.bv, e.bd, e.bl};
        oe = {ev[d], ec[d]};
        ee = {e.ev, held[d]};
        n_tests += 3;
        if (oh !== eh) begin
          n_fail++;
          $display("FAIL %s hdr dut%0d cyc %0d: got %h expected %h", cur, d, c, oh, eh);
        end
        if (ob !== eb) begin
          n_fail++;
          $display("FAIL %s byte dut%0d cyc %0d: got %h expected %h", cur, d, c, ob, eb);
        end
        if (oe !== ee) begin
          n_fail++;
          $display("FAIL %s err dut%0d cyc %0d: got %h expected %h", cur, d, c, oe, ee);
        end
      end
    end
    s_f.delete(); s_v.delete(); s_d.delete(); ex0.delete(); ex1.delete();
    @(negedge clock);
    frame_n = 1'b1; valid_n = 1'b1;
  endtask

  task automatic check_zero(input string tag);
    bit [18:0] o;
    for (int d = 0; d < 2; d++) begin
      o = {hv[d], hd[d], bv[d], bd[d], bl[d], ev[d], ec[d]};
      n_tests++;
      if (o !== 19'h0) begin
        n_fail++;
        $display("FAIL %s zero dut%0d: got %h expected 0", tag, d, o);
      end
    end
  endtask

  task automatic test_reset();
    cur = "reset";
    #2 reset_n = 1'b0;
    #1 check_zero("reset_async");
    repeat (3) @(posedge clock);
    #1 check_zero("reset_held");
    @(negedge clock) reset_n = 1'b1;
    held = '{3'd0, 3'd0};
  endtask

  task automatic test_basic();
    cur = "basic";
    clear_payload(); add_byte(8'hA5, 0); add_byte(8'h3C, 0);
    gen_packet(5, 0, -1, 1'b0); idle(2);
    run_stream(-1);
  endtask

  task automatic test_gaps();
    cur = "gaps";
    clear_payload(); add_byte(8'hA5, 0); add_byte(8'h3C, 0);
    pgap[3] = 3; pgap[12] = 3;
    gen_packet(5, 0, -1, 1'b0); idle(1);
    run_stream(-1);
  endtask

  task automatic test_short();
    cur = "short";
    clear_payload();
    gen_packet(6, 2, -1, 1'b0);
    add_byte(8'h5A, 0); add_byte(8'h11, 0);
    gen_packet(9, 0, -1, 1'b0); idle(1);
    run_stream(-1);
  endtask

  task automatic test_pad_err();
    cur = "pad_err";
    clear_payload(); add_rand(2, 0);
    gen_packet(7, 0, 2, 1'b0);
    clear_payload(); add_byte(8'hE7, 0);
    gen_packet(2, 0, -1, 1'b0); idle(1);
    run_stream(-1);
  endtask

  task automatic test_partial();
    cur = "partial";
    clear_payload(); add_rand(2, 0);
    repeat (4) begin void'(pbits.pop_back()); void'(pgap.pop_back()); end
    gen_packet(3, 0, -1, 1'b0); idle(1);
    run_stream(-1);
  endtask

  task automatic test_long();
    cur = "long";
    clear_payload(); add_rand(6, 0);
    gen_packet(12, 0, -1, 1'b0);
    clear_payload(); add_rand(4, 10);
    gen_packet(1, 0, -1, 1'b0);
    clear_payload(); add_rand(65, 0);
    gen_packet(2, 0, -1, 1'b0); idle(1);
    run_stream(-1);
  endtask

  task automatic test_proto();
    cur = "proto";
    clear_payload(); add_rand(1, 0);
    gen_packet(4, 0, -1, 1'b1);
    clear_payload();
    gen_packet(15, 0, -1, 1'b1); idle(1);
    run_stream(-1);
  endtask

  task automatic test_mid_reset();
    int start;
    cur = "mid_reset";
    clear_payload();
    gen_packet(8, 1, -1, 1'b0);
    start = s_f.size();
    add_byte(8'hC3, 0); add_rand(2, 0);
    gen_packet(10, 0, -1, 1'b0);
    run_stream(start + AW + PADC + 12);
    #2 reset_n = 1'b0;
    #1 check_zero("mid_reset_async");
    @(posedge clock); #1 check_zero("mid_reset_held");
    @(negedge clock) reset_n = 1'b1;
    held = '{3'd0, 3'd0};
    cur = "after_reset";
    clear_payload(); add_rand(2, 0);
    gen_packet(13, 0, -1, 1'b0); idle(1);
    run_stream(-1);
  endtask

  task automatic test_random();
    int kind, addr;
    cur = "random";
    for (int p = 0; p < 40; p++) begin
      kind = $urandom_range(0, 9);
      addr = $urandom_range(0, 15);
      clear_payload();
      case (kind)
        0: gen_packet(addr, $urandom_range(1, AW - 1), -1, 1'b0);
        1: begin add_rand(3, 0); gen_packet(addr, 0, $urandom_range(0, PADC - 1), 1'b0); end
        2: begin add_rand($urandom_range(0, 2), 20); gen_packet(addr, 0, -1, 1'b1); end
        3: begin
          add_rand($urandom_range(1, 3), 20);
          repeat ($urandom_range(1, 7)) begin void'(pbits.pop_back()); void'(pgap.pop_back()); end
          gen_packet(addr, 0, -1, 1'b0);
        end
        default: begin add_rand($urandom_range(1, 7), 20); gen_packet(addr, 0, -1, 1'b0); end
      endcase
      idle($urandom_range(0, 2));
    end
    run_stream(-1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_short();
    test_pad_err();
    test_partial();
    test_long();
    test_proto();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/router_port_rx.md
# router_port_rx

Parametrised serial packet receiver for one router input port. Decodes the per-port serial protocol: `frame_n` framing, LSB-first destination address, pad field, and `valid_n`-qualified payload bits. Emits the destination, then the assembled payload bytes with a last-byte marker, and reports protocol errors. One instance sits behind each of the N_PORTS input pins, ahead of the crossbar arbitration logic.

## Interface
- N_PORTS, 16, number of router output ports; ADDR_W = $clog2(N_PORTS), N_PORTS ≥ 2
- PAD_CYCLES, 5, pad cycles between the address field and the payload (≥ 1)
- BYTE_W, 8, payload word width in bits
- MAX_BYTES, 64, largest legal payload, in bytes
- clock  input  1  sole clock, all logic on posedge
- reset_n  input  1  asynchronous, active-low reset
- din  input  1  serial data
- frame_n  input  1  active-low frame; rises on the last payload bit
- valid_n  input  1  active-low payload bit qualifier
- hdr_valid  output  1  one-cycle pulse; hdr_dest valid
- hdr_dest  output  ADDR_W  decoded destination port
- byte_valid  output  1  one-cycle pulse; byte_data valid
- byte_data  output  BYTE_W  assembled byte, first received bit = bit 0
- byte_last  output  1  qualifies byte_valid; final byte of packet
- err_valid  output  1  one-cycle pulse on protocol error
- err_code  output  3  error code, held until next err_valid

## Operation
- Reset is asynchronous and active-low. All outputs are 0 and the FSM is in IDLE. A reset mid-packet discards the packet with no error reported.
- FSM states are IDLE, ADDR, PAD, DATA, DROP.
- IDLE: frame_n=0 samples din as address bit 0 → ADDR. If ADDR_W=1, go straight to PAD and emit the header.
- ADDR: shift din in LSB-first. After bit ADDR_W-1: hdr_valid=1, hdr_dest=address → PAD. frame_n=1 → ERR_SHORT(1) → IDLE.
- PAD: count PAD_CYCLES edges, din ignored, then → DATA.
  - valid_n=0 → ERR_PAD(2) → DROP.
  - frame_n=1 → ERR_SHORT(1) → IDLE.
- DATA, on each edge with valid_n=0: shift din into the bit counter / shift register.
  - At bit BYTE_W-1: byte_valid=1 and byte count +1.
  - If frame_n=1 on that bit: byte_last=1 → IDLE.
- DATA, valid_n=1 with frame_n=0: gap, nothing sampled, unlimited length.
- DATA, frame_n=1 with valid_n=0 on a non-final bit (bit count ≠ BYTE_W-1): ERR_PARTIAL(3), partial byte discarded → IDLE.
- DATA, frame_n=1 with valid_n=1: ERR_PROTO(4) → IDLE.
- DATA, valid bit sampled while byte count = MAX_BYTES: ERR_LONG(5) → DROP. Bytes already emitted stand, and none carries byte_last.
- DROP: ignore din and valid_n. frame_n=1 → IDLE with no further output.
- Byte counter width is $clog2(MAX_BYTES+1) and saturates; it never wraps.
- err_valid and byte_valid never assert in the same cycle. An error always ends the packet.

## Timing
- Let edge k sample the first frame_n=0.
- Address bits are sampled at edges k..k+ADDR_W-1. hdr_valid is high in the cycle after edge k+ADDR_W-1.
- Pad occupies edges k+ADDR_W..k+ADDR_W+PAD_CYCLES-1. The first payload bit is at edge k+ADDR_W+PAD_CYCLES.
- All outputs are registered with latency 1: each pulse is visible in the cycle after the edge that sampled the causing bit.
- Back-to-back packets: frame_n=0 on the edge right after the last bit (frame_n=1) starts a new packet with no idle cycle needed. The same applies on the edge after leaving DROP.
- There is no backpressure. The downstream side must accept one byte per BYTE_W cycles.

## Structure
- Package router_rx_pkg:
  - state enum rx_state_e {IDLE, ADDR, PAD, DATA, DROP}
  - error enum rx_err_e {ERR_NONE=0, ERR_SHORT=1, ERR_PAD=2, ERR_PARTIAL=3, ERR_PROTO=4, ERR_LONG=5}
- Sub-module router_sipo: BYTE_W-bit serial-in/parallel-out shift register with bit counter and clear.
  - Ports: shift_en, clear, din, word, word_done.
  - Reused for the address field with width ADDR_W.

## Test plan
Unless noted, N_PORTS=16, PAD_CYCLES=5, BYTE_W=8, MAX_BYTES=64.
- Port 5 with payload 0xA5, 0x3C, no gaps → hdr_dest=5 one cycle after edge k+3. First payload bit at edge k+9. 0xA5 (last=0), then 0x3C (last=1) 8 cycles apart. No err.
- Same packet with 3-cycle valid_n gaps mid-byte → identical bytes, each byte delayed by the gap cycles.
- frame_n rises after 2 address bits → err_code=1, no hdr_valid. A back-to-back packet to port 9 decodes correctly.
- valid_n=0 in pad cycle 3 → err_code=2, DROP. The rest of the frame produces no output.
- 12 payload bits then frame_n=1 → one byte with last=0, then err_code=3.
- MAX_BYTES=4, 6-byte frame → 4 bytes with last=0, err_code=5 one cycle after the first bit of byte 5.
- reset_n low mid-byte 2 → all outputs 0. The next packet decodes cleanly.
